// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared CPU package for the HI/LO multiply/divide unit.
//               Holds the op encodings, the FSM state enumeration, the
//               iteration count and a small magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    // op encodings driven by the decode stage (2'b11 is reserved)
    localparam logic [1:0] MD_IDLE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    // Number of iterative steps for both the Booth multiply and the divide
    localparam int ITER_COUNT = 32;

    // Controller states, explicitly sized and encoded
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MCALC = 3'd1,
        DCALC = 3'd2,
        FIN   = 3'd3,
        DZ    = 3'd4
    } md_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude of the most negative value.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage : mult_div_unit_pkg
`default_nettype wire

// File: rtl/mult_div_unit_div_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_step
// Description : One combinational restoring-division step on unsigned
//               magnitudes. The partial remainder is shifted left taking the
//               next dividend bit from the top of quot; the new quotient bit
//               is shifted into the bottom of quot.
// Ports       : rem       - current partial remainder (always < divisor)
//               quot      - remaining dividend bits / quotient bits so far
//               divisor   - divisor magnitude (non-zero)
//               next_rem  - partial remainder after this step
//               next_quot - quot after this step
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_step (
    input  logic [31:0] rem,
    input  logic [31:0] quot,
    input  logic [31:0] divisor,
    output logic [31:0] next_rem,
    output logic [31:0] next_quot
);

    logic [32:0] w_shifted;
    logic        w_ge;
    logic [31:0] w_diff;

    always_comb begin
        w_shifted = {rem, quot[31]};
        w_ge      = (w_shifted >= {1'b0, divisor});
        // Only used when w_ge is set, where the true difference is < divisor
        // and therefore fits in 32 bits, so the modulo-2^32 result is exact.
        w_diff    = w_shifted[31:0] - divisor;
        next_rem  = w_ge ? w_diff : w_shifted[31:0];
        next_quot = {quot[30:0], w_ge};
    end

endmodule : div_iter_step
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Signed 32x32 multiply / divide unit writing the HI and LO
//               registers. Multiply is a radix-2 Booth iteration (32 steps),
//               divide is a restoring iteration on magnitudes (32 steps)
//               with sign fix-up at the end. Latency from the accepting edge
//               to done is 33 cycles.
// Config      : MULT_DIV_FAST_MULT_EN - when defined, MULT is a single-cycle
//               combinational 64-bit product (done one cycle after accept).
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-high reset
//               op     - 00 idle, 01 MULT, 10 DIV, 11 reserved
//               a, b   - operands rs / rt
//               hi, lo - HI / LO result registers
//               busy   - operation in progress
//               done   - one-cycle result-valid pulse
//               div0   - one-cycle divide-by-zero pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    localparam logic [4:0] c_CNT_LOAD = 5'(ITER_COUNT - 1);

    md_state_t   r_state;
    md_state_t   w_next_state;
    logic [4:0]  r_count;
    logic        w_last;

    // Booth datapath: {acc[31:0], multiplier[31:0], q-1}
    logic [64:0] r_booth;
    logic [31:0] r_mcand;
    logic [32:0] w_acc_ext;
    logic [32:0] w_mcand_ext;
    logic [32:0] w_sum;
    logic [64:0] w_booth_next;

    // Divide datapath
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_dvsr;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [31:0] w_rem_next;
    logic [31:0] w_quot_next;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;

    // Next values of the registered outputs
    logic        w_busy_d;
    logic        w_done_d;
    logic        w_div0_d;

    assign w_last = (r_count == 5'd0);

`ifdef MULT_DIV_FAST_MULT_EN
    logic [63:0] w_fast_prod;
    // Low 64 bits of the product of the sign-extended operands equal the
    // signed 64-bit product.
    assign w_fast_prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
`endif

    // ------------------------------------------------------------------
    // Booth step. The add is done at 33 bits and the true sign (bit 32) is
    // shifted in, so a multiplicand of 0x80000000 does not overflow acc.
    // ------------------------------------------------------------------
    always_comb begin
        w_acc_ext   = {r_booth[64], r_booth[64:33]};
        w_mcand_ext = {r_mcand[31], r_mcand};
        case (r_booth[1:0])
            2'b01:   w_sum = w_acc_ext + w_mcand_ext;
            2'b10:   w_sum = w_acc_ext - w_mcand_ext;
            default: w_sum = w_acc_ext;
        endcase
        w_booth_next = {w_sum, r_booth[32:1]};
    end

    // ------------------------------------------------------------------
    // Shared restoring-divide step
    // ------------------------------------------------------------------
    div_iter_step u_div_step (
        .rem       (r_rem),
        .quot      (r_quot),
        .divisor   (r_dvsr),
        .next_rem  (w_rem_next),
        .next_quot (w_quot_next)
    );

    // Quotient truncates toward zero; remainder takes the dividend's sign
    always_comb begin
        w_div_q = r_q_neg ? (~w_quot_next + 32'd1) : w_quot_next;
        w_div_r = r_r_neg ? (~w_rem_next + 32'd1) : w_rem_next;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (op == MD_MULT) begin
`ifdef MULT_DIV_FAST_MULT_EN
                    w_next_state = FIN;
`else
                    w_next_state = MCALC;
`endif
                end else if (op == MD_DIV) begin
                    w_next_state = (b == 32'd0) ? DZ : DCALC;
                end
            end
            MCALC:   if (w_last) w_next_state = FIN;
            DCALC:   if (w_last) w_next_state = FIN;
            FIN:     w_next_state = IDLE;
            DZ:      w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (values registered on the next edge).
    // div0 is raised on DZ entry so it appears the cycle after accept;
    // done follows the FIN cycle so it appears one cycle after hi/lo load.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_d = (w_next_state != IDLE);
        w_done_d = (r_state == FIN);
        w_div0_d = (w_next_state == DZ);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            div0 <= 1'b0;
        end else begin
            busy <= w_busy_d;
            done <= w_done_d;
            div0 <= w_div0_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO. hi/lo load only on FIN entry, from the final
    // step's combinational result.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 5'd0;
            r_booth <= 65'd0;
            r_mcand <= 32'd0;
            r_rem   <= 32'd0;
            r_quot  <= 32'd0;
            r_dvsr  <= 32'd0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op == MD_MULT) begin
`ifdef MULT_DIV_FAST_MULT_EN
                        hi <= w_fast_prod[63:32];
                        lo <= w_fast_prod[31:0];
`else
                        r_booth <= {32'd0, b, 1'b0};
                        r_mcand <= a;
                        r_count <= c_CNT_LOAD;
`endif
                    end else if ((op == MD_DIV) && (b != 32'd0)) begin
                        r_rem   <= 32'd0;
                        r_quot  <= abs32(a);
                        r_dvsr  <= abs32(b);
                        r_q_neg <= a[31] ^ b[31];
                        r_r_neg <= a[31];
                        r_count <= c_CNT_LOAD;
                    end
                end
                MCALC: begin
                    r_booth <= w_booth_next;
                    if (w_last) begin
                        hi <= w_booth_next[64:33];
                        lo <= w_booth_next[32:1];
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                DCALC: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    if (w_last) begin
                        hi <= w_div_r;
                        lo <= w_div_q;
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. A table of directed
//               MULT/DIV vectors with hand-computed results, plus sequences
//               for reserved ops, mid-operation requests and mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam int c_MUL_LAT = 1;
`else
    localparam int c_MUL_LAT = 33;
`endif
    localparam int c_DIV_LAT = 33;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          lat;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[12];

    mult_div_unit dut (
        .clock (clock),
        .reset (reset),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, then watch for done/div0 with a bounded cycle budget.
    // Sample k is taken #1 after edge k, edge 0 being the accepting edge.
    task automatic run_op(input vec_t v);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int          got;
        prev_hi = hi;
        prev_lo = lo;
        op  = v.op;
        a   = v.a;
        b   = v.b;
        got = -1;
        for (int k = 0; k <= 40 && got < 0; k++) begin
            @(posedge clock);
            #1;
            if (k == 0) begin
                check({v.name, ".busy_after_accept"}, 32'(busy), 32'd1);
                // Garbage on the inputs while busy must not matter
                op = MD_IDLE;
                a  = $urandom;
                b  = $urandom;
            end
            if (v.lat >= 2 && k == v.lat - 2) begin
                check({v.name, ".hi_stable"}, hi, prev_hi);
                check({v.name, ".lo_stable"}, lo, prev_lo);
            end
            if (done || div0) got = k;
        end
        check({v.name, ".latency"}, 32'(got), 32'(v.lat));
        check({v.name, ".done"}, 32'(done), 32'(!v.div0));
        check({v.name, ".div0"}, 32'(div0), 32'(v.div0));
        check({v.name, ".hi"}, hi, v.hi);
        check({v.name, ".lo"}, lo, v.lo);
        @(posedge clock);
        #1;
        check({v.name, ".pulse_end"}, {30'd0, done, div0}, 32'd0);
        check({v.name, ".busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] keep_hi;
        logic [31:0] keep_lo;

        //              name          op       a             b             hi            lo            div0  lat
        vecs[0]  = '{"mul_7xm3",      MD_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, c_MUL_LAT};
        vecs[1]  = '{"div_m7d2",      MD_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, c_DIV_LAT};
        vecs[2]  = '{"div_5d0",       MD_DIV,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 0};
        vecs[3]  = '{"div_minm1",     MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, c_DIV_LAT};
        vecs[4]  = '{"mul_minxmin",   MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, c_MUL_LAT};
        vecs[5]  = '{"mul_m1xm1",     MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, c_MUL_LAT};
        vecs[6]  = '{"div_100d7",     MD_DIV,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, c_DIV_LAT};
        vecs[7]  = '{"div_7dm2",      MD_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, c_DIV_LAT};
        vecs[8]  = '{"mul_x0",        MD_MULT, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, c_MUL_LAT};
        vecs[9]  = '{"mul_maxxmin",   MD_MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, c_MUL_LAT};
        vecs[10] = '{"div_mind1",     MD_DIV,  32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000, 1'b0, c_DIV_LAT};
        vecs[11] = '{"div_m100dm7",   MD_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, c_DIV_LAT};

        // Reset state
        #12;
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        check("rst.flags", {29'd0, busy, done, div0}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reserved and idle ops leave everything untouched
        keep_hi = hi;
        keep_lo = lo;
        op = 2'b11;
        a  = 32'd9;
        b  = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check("rsvd.flags", {29'd0, busy, done, div0}, 32'd0);
        end
        op = MD_IDLE;
        @(posedge clock);
        #1;
        check("rsvd.hi", hi, keep_hi);
        check("rsvd.lo", lo, keep_lo);

        // MULT with a DIV-by-zero request and new operands held mid-operation
        begin
            int got;
            int drop_k;
            drop_k = (c_MUL_LAT > 20) ? 20 : c_MUL_LAT;
            op  = MD_MULT;
            a   = 32'h00010000;
            b   = 32'h00010000;
            got = -1;
            for (int k = 0; k <= 40 && got < 0; k++) begin
                @(posedge clock);
                #1;
                if (k == 0) begin
                    op = MD_DIV;
                    a  = 32'h00000005;
                    b  = 32'h00000000;
                end
                if (k == drop_k) op = MD_IDLE;
                if (div0) begin
                    checks++;
                    failures++;
                    $display("FAIL midop.div0 actual=1 expected=0 at k=%0d", k);
                end
                if (done) got = k;
                else if (k < c_MUL_LAT) check("midop.busy", 32'(busy), 32'd1);
            end
            check("midop.latency", 32'(got), 32'(c_MUL_LAT));
            check("midop.hi", hi, 32'h00000001);
            check("midop.lo", lo, 32'h00000000);
            for (int k = 0; k < 3; k++) begin
                @(posedge clock);
                #1;
                check("midop.quiet", {29'd0, busy, done, div0}, 32'd0);
            end
        end

        // Reset in the middle of a DIV, then a clean MULT
        op = MD_DIV;
        a  = 32'd100;
        b  = 32'd7;
        @(posedge clock);
        #1;
        op = MD_IDLE;
        repeat (10) @(posedge clock);
        #1;
        check("abort.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        check("abort.flags", {29'd0, busy, done, div0}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("abort.idle", {29'd0, busy, done, div0}, 32'd0);
        v = '{"mul_3x4", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, c_MUL_LAT};
        run_op(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
